// File: rtl/pipeline_param.sv
// Parametrised 3-stage in-order ALU pipeline (ID | EX | WB) with full forwarding,
// valid/ready instruction intake, a 2-cycle multiplier and a retire counter.
module pipeline_param #(
    parameter int unsigned XLEN = 8,
    parameter int unsigned NREG = 4,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3+3*AW-1:0]   inst,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [AW-1:0]       dbg_raddr,
    output logic [XLEN-1:0]     dbg_rdata,
    output logic                wb_valid,
    output logic [AW-1:0]       wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic [CNTW-1:0]     retire_count
);

    localparam int unsigned IW = 3 + 3 * AW;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MUL = 3'd6,
        OP_LI  = 3'd7
    } op_e;

    typedef enum logic {
        EX_RUN  = 1'b0,
        EX_MUL2 = 1'b1
    } ex_state_e;

    logic [XLEN-1:0] rf [NREG];

    op_e             id_op;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic [AW-1:0]   id_rd;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    ex_state_e       ex_state;
    op_e             idex_op;
    logic [AW-1:0]   idex_rd;
    logic [XLEN-1:0] idex_a;
    logic [XLEN-1:0] idex_b;
    logic [XLEN-1:0] mul_q;
    logic [XLEN-1:0] ex_result;
    logic            mul_first;
    logic            ex_writes;

    logic            exwb_we;
    logic [AW-1:0]   exwb_rd;
    logic [XLEN-1:0] exwb_data;

    assign id_op  = op_e'(inst[IW-1 -: 3]);
    assign id_rs1 = inst[3*AW-1 -: AW];
    assign id_rs2 = inst[2*AW-1 -: AW];
    assign id_rd  = inst[AW-1:0];
    assign id_imm = XLEN'({id_rs1, id_rs2});

    // A MUL in its first EX cycle has no result yet and blocks intake.
    assign mul_first  = (ex_state == EX_RUN) && (idex_op == OP_MUL);
    assign ex_writes  = (idex_op != OP_NOP) && !mul_first;
    assign inst_ready = !rst && !mul_first;
    assign dbg_rdata  = rf[dbg_raddr];

    always_comb begin
        ex_result = '0;
        case (idex_op)
            OP_ADD:  ex_result = idex_a + idex_b;
            OP_SUB:  ex_result = idex_a - idex_b;
            OP_AND:  ex_result = idex_a & idex_b;
            OP_OR:   ex_result = idex_a | idex_b;
            OP_XOR:  ex_result = idex_a ^ idex_b;
            OP_MUL:  ex_result = mul_q;
            OP_LI:   ex_result = idex_a;
            default: ex_result = '0;
        endcase
    end

    // Operand forwarding: completed EX result beats EX/WB, which beats the RF.
    always_comb begin
        op_a = rf[id_rs1];
        op_b = rf[id_rs2];
        if (exwb_we && (exwb_rd == id_rs1)) op_a = exwb_data;
        if (exwb_we && (exwb_rd == id_rs2)) op_b = exwb_data;
        if (ex_writes && (idex_rd == id_rs1)) op_a = ex_result;
        if (ex_writes && (idex_rd == id_rs2)) op_b = ex_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_state     <= EX_RUN;
            idex_op      <= OP_NOP;
            idex_rd      <= '0;
            idex_a       <= '0;
            idex_b       <= '0;
            mul_q        <= '0;
            exwb_we      <= 1'b0;
            exwb_rd      <= '0;
            exwb_data    <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            retire_count <= '0;
            rf           <= '{default: '0};
        end else begin
            case (ex_state)
                EX_RUN: begin
                    if (idex_op == OP_MUL) begin
                        ex_state <= EX_MUL2;
                        mul_q    <= idex_a * idex_b;
                    end
                end
                EX_MUL2: ex_state <= EX_RUN;
                default: ex_state <= EX_RUN;
            endcase

            // ID/EX holds during the MUL stall; otherwise a non-transfer is a bubble.
            if (!mul_first) begin
                if (inst_valid) begin
                    idex_op <= id_op;
                    idex_rd <= id_rd;
                    idex_a  <= (id_op == OP_LI) ? id_imm : op_a;
                    idex_b  <= op_b;
                end else begin
                    idex_op <= OP_NOP;
                end
            end

            exwb_we   <= ex_writes;
            exwb_rd   <= idex_rd;
            exwb_data <= ex_result;

            wb_valid <= exwb_we;
            if (exwb_we) begin
                rf[exwb_rd]  <= exwb_data;
                wb_rd        <= exwb_rd;
                wb_data      <= exwb_data;
                retire_count <= retire_count + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_param.sv
// Randomised + directed bench for pipeline_param against a sequential-execution
// reference model with a timed retire queue.
module tb_pipeline_param;

    localparam int unsigned XLEN = 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = 2;
    localparam int unsigned CNTW = 4;
    localparam int unsigned IW   = 3 + 3 * AW;

    logic            clk = 1'b0;
    logic            rst;
    logic [IW-1:0]   inst;
    logic            inst_valid;
    logic            inst_ready;
    logic [AW-1:0]   dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [CNTW-1:0] retire_count;

    pipeline_param #(.XLEN(XLEN), .NREG(NREG), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ret_t;

    ret_t            q[$];
    logic [XLEN-1:0] spec_rf [NREG];
    logic [XLEN-1:0] arch_rf [NREG];
    int              cyc;
    int              n_checks;
    int              n_errors;
    int unsigned     cnt_model;
    logic            mul_prev;
    logic            rst_prev;
    logic            last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [AW-1:0] rs1,
                                         input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
        return {op, rs1, rs2, rd};
    endfunction

    // Architectural meaning of one instruction, as if executed alone and in order.
    function automatic logic [XLEN-1:0] execute(input logic [2:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b, input logic [2*AW-1:0] imm);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return a * b;
            3'd7:    return XLEN'(imm);
            default: return '0;
        endcase
    endfunction

    task automatic cycle(input logic v, input logic [IW-1:0] ins, input logic r);
        logic [2:0]      op;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   da;
        logic            exp_ready;
        logic [XLEN-1:0] res;
        ret_t            ent;
        @(negedge clk);
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            check("wb_valid", 32'(wb_valid), 32'd1);
            check("wb_rd", 32'(wb_rd), 32'(q[0].rd));
            check("wb_data", 32'(wb_data), 32'(q[0].data));
            arch_rf[q[0].rd] = q[0].data;
            cnt_model = (cnt_model + 1) % (32'd1 << CNTW);
            void'(q.pop_front());
        end else begin
            check("wb_valid", 32'(wb_valid), 32'd0);
        end
        if (rst_prev) begin
            check("wb_rd_rst", 32'(wb_rd), 32'd0);
            check("wb_data_rst", 32'(wb_data), 32'd0);
        end
        check("retire_count", 32'(retire_count), cnt_model);

        rst        = r;
        inst_valid = v;
        inst       = ins;
        da         = AW'($urandom);
        dbg_raddr  = da;
        #1;
        exp_ready = !r && !mul_prev;
        check("inst_ready", 32'(inst_ready), 32'(exp_ready));
        check("dbg_rdata", 32'(dbg_rdata), 32'(arch_rf[da]));

        op  = ins[IW-1 -: 3];
        rs1 = ins[3*AW-1 -: AW];
        rs2 = ins[2*AW-1 -: AW];
        rd  = ins[AW-1:0];
        last_acc = v && exp_ready;
        mul_prev = last_acc && (op == 3'd6);
        rst_prev = r;
        if (r) begin
            q.delete();
            spec_rf   = '{default: '0};
            arch_rf   = '{default: '0};
            cnt_model = 0;
            mul_prev  = 1'b0;
        end else if (last_acc && op != 3'd0) begin
            res = execute(op, spec_rf[rs1], spec_rf[rs2], {rs1, rs2});
            spec_rf[rd] = res;
            ent.due  = cyc + ((op == 3'd6) ? 4 : 3);
            ent.rd   = rd;
            ent.data = res;
            q.push_back(ent);
        end
    endtask

    task automatic send(input logic [IW-1:0] ins);
        int tries = 0;
        do begin
            cycle(1'b1, ins, 1'b0);
            tries++;
        end while (!last_acc && tries < 4);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic reg_check(input logic [AW-1:0] idx, input logic [XLEN-1:0] exp);
        cycle(1'b0, '0, 1'b0);
        dbg_raddr = idx;
        #1;
        check($sformatf("rf[%0d]", idx), 32'(dbg_rdata), 32'(exp));
    endtask

    initial begin
        rst        = 1'b1;
        inst_valid = 1'b0;
        inst       = '0;
        dbg_raddr  = '0;
        spec_rf    = '{default: '0};
        arch_rf    = '{default: '0};
        cyc        = 0;
        n_checks   = 0;
        n_errors   = 0;
        cnt_model  = 0;
        mul_prev   = 1'b0;
        rst_prev   = 1'b1;
        last_acc   = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state and basic LI / forwarding / ALU chain
        cycle(1'b0, '0, 1'b1);
        send(mk(3'd7, 2'b01, 2'b01, 2'd1));
        send(mk(3'd7, 2'b00, 2'b11, 2'd2));
        send(mk(3'd1, 2'd1, 2'd2, 2'd3));
        send(mk(3'd2, 2'd2, 2'd1, 2'd0));
        send(mk(3'd5, 2'd0, 2'd3, 2'd0));
        send(mk(3'd3, 2'd0, 2'd3, 2'd1));
        idle(4);
        reg_check(2'd0, 8'hF6);
        reg_check(2'd1, 8'h00);
        reg_check(2'd2, 8'h03);
        reg_check(2'd3, 8'h08);

        // MUL stall and forwarding of the product
        send(mk(3'd6, 2'd3, 2'd3, 2'd3));
        send(mk(3'd3, 2'd3, 2'd3, 2'd2));
        idle(4);
        reg_check(2'd3, 8'd64);
        reg_check(2'd2, 8'd64);

        // Reset during the second MUL cycle discards it
        cycle(1'b1, mk(3'd6, 2'd3, 2'd2, 2'd1), 1'b0);
        cycle(1'b1, mk(3'd1, 2'd1, 2'd1, 2'd0), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        idle(4);
        for (int i = 0; i < 4; i++) reg_check(AW'(i), 8'h00);
        check("retire_count_after_rst", 32'(retire_count), 32'd0);

        // Intermittent valid
        send(mk(3'd7, 2'b00, 2'b10, 2'd1));
        cycle(1'b1, mk(3'd1, 2'd1, 2'd1, 2'd2), 1'b0);
        cycle(1'b0, mk(3'd1, 2'd2, 2'd2, 2'd3), 1'b0);
        cycle(1'b1, mk(3'd1, 2'd2, 2'd1, 2'd3), 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b1, mk(3'd1, 2'd3, 2'd3, 2'd0), 1'b0);
        idle(4);
        reg_check(2'd0, 8'd12);

        // Counter wrap: 17 retirements on a 4-bit counter
        cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 17; i++) send(mk(3'd7, AW'(i >> 2), AW'(i), AW'(i)));
        idle(4);
        check("retire_wrap", 32'(retire_count), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 63) == 0);
        idle(6);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
